// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 registered demultiplexer with valid/ready handshakes.
// Each accepted input beat is routed to output A (select=0) or output B (select=1).
// Each output has its own output register, so a stalled consumer never blocks the
// other one. A per-output counter records every completed output handshake.
//
// Optional feature, enabled by defining STREAM_DEMUX_LAST_LOCK_EN:
// adds an i_last input and a two-state lock FSM (IDLE/LOCKED). While LOCKED,
// the destination latched on the first beat of a packet is held until the beat
// with i_last=1.
//
// Handshake semantics, for the input and both outputs: a beat transfers on a
// rising edge when valid && ready. A holder with valid=1 keeps its data and valid
// stable until ready. o_ready is combinational, does not look at i_valid, and
// reflects whether the slot picked by the effective select can take a beat.
module stream_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_select,
`ifdef STREAM_DEMUX_LAST_LOCK_EN
  input  logic                  i_last,
`endif
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_a_data,
  output logic                  o_a_valid,
  input  logic                  i_a_ready,
  output logic [DATA_WIDTH-1:0] o_b_data,
  output logic                  o_b_valid,
  input  logic                  i_b_ready,
  output logic [CNT_WIDTH-1:0]  o_a_count,
  output logic [CNT_WIDTH-1:0]  o_b_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  a_valid_q, a_valid_d;
  logic                  b_valid_q, b_valid_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
  logic [CNT_WIDTH-1:0]  a_count_q, a_count_d;
  logic [CNT_WIDTH-1:0]  b_count_q, b_count_d;

  logic sel_eff;
  logic a_drain, b_drain;
  logic a_can_load, b_can_load;
  logic accept;
  logic load_a, load_b;

`ifdef STREAM_DEMUX_LAST_LOCK_EN
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // state_q is the lock FSM state; kept as a named signal so checkers can bind to it.
  lock_state_t state_q, state_d;
  logic        lock_sel_q, lock_sel_d;

  // While a packet is in flight the latched destination overrides i_select.
  always_comb begin
    sel_eff = (state_q == LOCKED) ? lock_sel_q : i_select;
  end

  // Next-state for the packet lock: enter on a non-last accept, leave on the last beat.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE: begin
        if (accept && !i_last) begin
          state_d    = LOCKED;
          lock_sel_d = i_select;
        end
      end
      LOCKED: begin
        if (accept && i_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lock FSM register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      lock_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end
`else
  // Without packet locking every beat is routed by its own select.
  always_comb begin
    sel_eff = i_select;
  end
`endif

  // Slot availability, input ready and per-slot load strobes.
  always_comb begin
    a_drain    = a_valid_q && i_a_ready;
    b_drain    = b_valid_q && i_b_ready;
    a_can_load = !a_valid_q || i_a_ready;
    b_can_load = !b_valid_q || i_b_ready;
    o_ready    = sel_eff ? b_can_load : a_can_load;
    accept     = i_valid && o_ready;
    load_a     = accept && !sel_eff;
    load_b     = accept && sel_eff;
  end

  // Next-state for both output slots and counters; a load wins over a drain.
  always_comb begin
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (a_drain) begin
      a_valid_d = 1'b0;
      a_count_d = a_count_q + CNT_ONE;
    end
    if (b_drain) begin
      b_valid_d = 1'b0;
      b_count_d = b_count_q + CNT_ONE;
    end
    if (load_a) begin
      a_valid_d = 1'b1;
      a_data_d  = i_data;
    end
    if (load_b) begin
      b_valid_d = 1'b1;
      b_data_d  = i_data;
    end
  end

  // Output slot and counter registers; reset drops any held beat.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    o_a_valid = a_valid_q;
    o_b_valid = b_valid_q;
    o_a_data  = a_data_q;
    o_b_data  = b_data_q;
    o_a_count = a_count_q;
    o_b_count = b_count_q;
  end

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux. A second, narrow instance (8-bit data, 3-bit
// counters) shares the same stimulus so counter wrap-around is exercised often.
module tb_stream_demux;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_select;
  logic        i_last;
  logic        i_a_ready;
  logic        i_b_ready;

  logic        o_ready,   o_a_valid,   o_b_valid;
  logic [31:0] o_a_data,  o_b_data;
  logic [15:0] o_a_count, o_b_count;

  logic        o_ready_w, o_a_valid_w, o_b_valid_w;
  logic [7:0]  o_a_data_w, o_b_data_w;
  logic [2:0]  o_a_count_w, o_b_count_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending beats per destination (at most one each), delivered counts,
  // and the packet lock (destination held from a packet's first beat to its last).
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          cnt_a;
  int          cnt_b;
  logic        m_locked;
  logic        m_lock_sel;

  stream_demux dut (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_select(i_select),
`ifdef STREAM_DEMUX_LAST_LOCK_EN
    .i_last(i_last),
`endif
    .o_ready(o_ready), .o_a_data(o_a_data), .o_a_valid(o_a_valid), .i_a_ready(i_a_ready),
    .o_b_data(o_b_data), .o_b_valid(o_b_valid), .i_b_ready(i_b_ready),
    .o_a_count(o_a_count), .o_b_count(o_b_count)
  );

  stream_demux #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut_w (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data[7:0]), .i_valid(i_valid),
    .i_select(i_select),
`ifdef STREAM_DEMUX_LAST_LOCK_EN
    .i_last(i_last),
`endif
    .o_ready(o_ready_w), .o_a_data(o_a_data_w), .o_a_valid(o_a_valid_w), .i_a_ready(i_a_ready),
    .o_b_data(o_b_data_w), .o_b_valid(o_b_valid_w), .i_b_ready(i_b_ready),
    .o_a_count(o_a_count_w), .o_b_count(o_b_count_w)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_sel();
`ifdef STREAM_DEMUX_LAST_LOCK_EN
    return m_locked ? m_lock_sel : i_select;
`else
    return i_select;
`endif
  endfunction

  task automatic model_clear();
    exp_a_q.delete();
    exp_b_q.delete();
    cnt_a      = 0;
    cnt_b      = 0;
    m_locked   = 1'b0;
    m_lock_sel = 1'b0;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d, input logic l);
    i_valid  = v;
    i_select = s;
    i_data   = d;
    i_last   = l;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  // One clock cycle: compare outputs with the model at the falling edge, then
  // advance the model by what transfers on the following rising edge.
  task automatic step();
    logic sel, pa, pb, rdy, acc, da, db;
    @(negedge clk);
    sel = model_sel();
    pa  = (exp_a_q.size() != 0);
    pb  = (exp_b_q.size() != 0);
    rdy = sel ? (!pb || i_b_ready) : (!pa || i_a_ready);
    check("a_valid", 64'(o_a_valid), 64'(pa));
    check("b_valid", 64'(o_b_valid), 64'(pb));
    check("ready",   64'(o_ready),   64'(rdy));
    if (pa) check("a_data", 64'(o_a_data), 64'(exp_a_q[0]));
    if (pb) check("b_data", 64'(o_b_data), 64'(exp_b_q[0]));
    check("a_count", 64'(o_a_count), 64'(cnt_a & 32'hFFFF));
    check("b_count", 64'(o_b_count), 64'(cnt_b & 32'hFFFF));
    check("w_a_valid", 64'(o_a_valid_w), 64'(pa));
    check("w_b_valid", 64'(o_b_valid_w), 64'(pb));
    check("w_ready",   64'(o_ready_w),   64'(rdy));
    if (pa) check("w_a_data", 64'(o_a_data_w), 64'(exp_a_q[0] & 32'hFF));
    if (pb) check("w_b_data", 64'(o_b_data_w), 64'(exp_b_q[0] & 32'hFF));
    check("w_a_count", 64'(o_a_count_w), 64'(cnt_a % 8));
    check("w_b_count", 64'(o_b_count_w), 64'(cnt_b % 8));
    acc = i_valid && rdy;
    da  = pa && i_a_ready;
    db  = pb && i_b_ready;
    @(posedge clk);
    if (da) begin
      void'(exp_a_q.pop_front());
      cnt_a++;
    end
    if (db) begin
      void'(exp_b_q.pop_front());
      cnt_b++;
    end
    if (acc) begin
      if (sel) exp_b_q.push_back(i_data);
      else     exp_a_q.push_back(i_data);
`ifdef STREAM_DEMUX_LAST_LOCK_EN
      if (!m_locked && !i_last) begin
        m_locked   = 1'b1;
        m_lock_sel = i_select;
      end else if (m_locked && i_last) begin
        m_locked = 1'b0;
      end
`endif
    end
    #1;
  endtask

  initial begin
    i_reset   = 1'b1;
    i_a_ready = 1'b1;
    i_b_ready = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    model_clear();

    // Reset values while reset is held.
    #1;
    check("rst_a_valid", 64'(o_a_valid), 64'(0));
    check("rst_b_valid", 64'(o_b_valid), 64'(0));
    check("rst_a_data",  64'(o_a_data),  64'(0));
    check("rst_b_data",  64'(o_b_data),  64'(0));
    check("rst_a_count", 64'(o_a_count), 64'(0));
    check("rst_b_count", 64'(o_b_count), 64'(0));
    do_reset();

    // Single beats to A then B.
    drive(1'b1, 1'b0, 32'h11, 1'b1); step();
    check("t1_a_data", 64'(o_a_data), 64'(32'h11));
    check("t1_a_valid", 64'(o_a_valid), 64'(1));
    drive(1'b1, 1'b1, 32'h22, 1'b1); step();
    check("t1_b_data", 64'(o_b_data), 64'(32'h22));
    drive(1'b0, 1'b0, 32'h0, 1'b1);  step(); step();
    check("t1_a_cnt", 64'(o_a_count), 64'(1));
    check("t1_b_cnt", 64'(o_b_count), 64'(1));

    // Backpressure on A: second beat must wait, first held stable.
    do_reset();
    i_a_ready = 1'b0;
    drive(1'b1, 1'b0, 32'hA0, 1'b1); step();
    drive(1'b1, 1'b0, 32'hA1, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check("t2_held", 64'(o_a_data), 64'(32'hA0));
    check("t2_not_ready", 64'(o_ready), 64'(0));
    i_a_ready = 1'b1; step();
    check("t2_second", 64'(o_a_data), 64'(32'hA1));
    drive(1'b0, 1'b0, 32'h0, 1'b1); step(); step();
    check("t2_a_cnt", 64'(o_a_count), 64'(2));

    // Stalled A does not block B.
    do_reset();
    i_a_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h5, 1'b1); step();
    drive(1'b1, 1'b1, 32'h6, 1'b1); step();
    drive(1'b1, 1'b1, 32'h7, 1'b1); step();
    drive(1'b0, 1'b0, 32'h0, 1'b1); step(); step();
    check("t3_a_hold", 64'(o_a_data), 64'(32'h5));
    check("t3_b_cnt", 64'(o_b_count), 64'(2));
    i_a_ready = 1'b1; step(); step();

    // Streaming: 100 back-to-back beats to B.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, $urandom, 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1); step(); step();
    check("t4_b_cnt", 64'(o_b_count), 64'(100));

    // Asynchronous reset while A holds a beat: clears with no clock edge.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, $urandom, 1'b1);
      step();
    end
    i_a_ready = 1'b0;
    drive(1'b1, 1'b0, 32'hCAFE, 1'b1); step();
    drive(1'b0, 1'b0, 32'h0, 1'b1); step();
    check("t5_pre_valid", 64'(o_a_valid), 64'(1));
    #1;
    i_reset = 1'b1;
    #1;
    check("t5_a_valid", 64'(o_a_valid), 64'(0));
    check("t5_a_count", 64'(o_a_count), 64'(0));
    check("t5_a_data",  64'(o_a_data),  64'(0));
    model_clear();
    @(posedge clk);
    #1;
    i_reset   = 1'b0;
    i_a_ready = 1'b1;
    step(); step();

`ifdef STREAM_DEMUX_LAST_LOCK_EN
    // Packet lock: three beats with toggling select all land on B.
    do_reset();
    drive(1'b1, 1'b1, 32'h101, 1'b0); step();
    drive(1'b1, 1'b0, 32'h102, 1'b0); step();
    drive(1'b1, 1'b0, 32'h103, 1'b1); step();
    drive(1'b1, 1'b0, 32'h104, 1'b1); step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);   step(); step();
    check("t6_b_cnt", 64'(o_b_count), 64'(3));
    check("t6_a_cnt", 64'(o_a_count), 64'(1));
    check("t6_a_data", 64'(o_a_data), 64'(32'h104));
`endif

    // Random traffic with random consumer stalls.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 2) == 0));
      i_a_ready = ($urandom_range(0, 9) < 7);
      i_b_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    i_a_ready = 1'b1;
    i_b_ready = 1'b1;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
